fifo_ram_ctrl: RTL and testbench

//  Single-clock FIFO controller that sequences the 16x8 simple dual-port RAM (wr/rd ports tied to one clock).

---
 rtl/fifo_ram_ctrl.sv | 153 +++++++++++++++
 tb/tb_fifo_ram_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ram_ctrl.sv
// First-word-fall-through FIFO controller for a 16x8 registered-read dual-port RAM.
// A 2-entry output buffer absorbs the one-cycle read latency so the consumer sees valid/ready at full rate.
module fifo_ram_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [ADDR_W+1:0] count,
  output logic              ram_full
);

  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    OB_EMPTY = 2'd0,
    OB_ONE   = 2'd1,
    OB_TWO   = 2'd2
  } ob_state_t;

  logic [ADDR_W:0]   wptr_r;
  logic [ADDR_W:0]   rptr_r;
  logic [ADDR_W:0]   wptr_nxt_s;
  logic [ADDR_W:0]   rptr_nxt_s;
  logic [ADDR_W:0]   ram_cnt_s;
  logic [ADDR_W:0]   ram_cnt_nxt_s;
  logic              inflight_r;
  ob_state_t         ob_state_r;
  ob_state_t         ob_state_nxt_s;
  logic [DATA_W-1:0] ob_head_r;
  logic [DATA_W-1:0] ob_tail_r;
  logic [DATA_W-1:0] ob_head_nxt_s;
  logic [DATA_W-1:0] ob_tail_nxt_s;
  logic              ram_full_r;
  logic              out_valid_r;
  logic [ADDR_W+1:0] count_r;
  logic [ADDR_W+1:0] count_nxt_s;
  logic              push_s;
  logic              pop_s;
  logic              ret_s;
  logic              rd_issue_s;
  logic [2:0]        pend_s;

  // in_ready is held low while reset is asserted and opens as soon as it is released
  assign in_ready  = rst_n & ~ram_full_r;
  assign out_valid = out_valid_r;
  assign out_data  = ob_head_r;
  assign count     = count_r;
  assign ram_full  = ram_full_r;

  assign push_s = in_valid & in_ready;
  assign pop_s  = out_valid_r & out_ready;
  assign ret_s  = inflight_r;

  // Only issue a read when the buffer will have room for it after this cycle's pop
  assign ram_cnt_s  = wptr_r - rptr_r;
  assign pend_s     = {1'b0, ob_state_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign rd_issue_s = (ram_cnt_s != {(ADDR_W+1){1'b0}}) && (pend_s < 3'd2);

  assign wptr_nxt_s    = wptr_r + {{ADDR_W{1'b0}}, push_s};
  assign rptr_nxt_s    = rptr_r + {{ADDR_W{1'b0}}, rd_issue_s};
  assign ram_cnt_nxt_s = wptr_nxt_s - rptr_nxt_s;
  assign count_nxt_s   = {1'b0, ram_cnt_nxt_s}
                       + {{(ADDR_W+1){1'b0}}, rd_issue_s}
                       + {{ADDR_W{1'b0}}, ob_state_nxt_s};

  assign ram_wr_en   = push_s;
  assign ram_wr_addr = wptr_r[ADDR_W-1:0];
  assign ram_wr_data = in_data;
  assign ram_rd_en   = rd_issue_s;
  assign ram_rd_addr = rptr_r[ADDR_W-1:0];

  // Output buffer next state: head is always the oldest word, tail the one behind it
  always_comb begin
    ob_state_nxt_s = ob_state_r;
    ob_head_nxt_s  = ob_head_r;
    ob_tail_nxt_s  = ob_tail_r;
    case (ob_state_r)
      OB_EMPTY: begin
        if (ret_s) begin
          ob_state_nxt_s = OB_ONE;
          ob_head_nxt_s  = ram_rd_data;
        end else begin
          ob_state_nxt_s = OB_EMPTY;
        end
      end
      OB_ONE: begin
        if (ret_s && pop_s) begin
          ob_head_nxt_s = ram_rd_data;
        end else if (ret_s) begin
          ob_state_nxt_s = OB_TWO;
          ob_tail_nxt_s  = ram_rd_data;
        end else if (pop_s) begin
          ob_state_nxt_s = OB_EMPTY;
        end else begin
          ob_state_nxt_s = OB_ONE;
        end
      end
      OB_TWO: begin
        if (ret_s && pop_s) begin
          ob_head_nxt_s = ob_tail_r;
          ob_tail_nxt_s = ram_rd_data;
        end else if (pop_s) begin
          ob_state_nxt_s = OB_ONE;
          ob_head_nxt_s  = ob_tail_r;
        end else begin
          ob_state_nxt_s = OB_TWO;
        end
      end
      default: begin
        ob_state_nxt_s = OB_EMPTY;
      end
    endcase
  end

  // State, pointers and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r      <= {(ADDR_W+1){1'b0}};
      rptr_r      <= {(ADDR_W+1){1'b0}};
      inflight_r  <= 1'b0;
      ob_state_r  <= OB_EMPTY;
      ob_head_r   <= {DATA_W{1'b0}};
      ob_tail_r   <= {DATA_W{1'b0}};
      ram_full_r  <= 1'b0;
      out_valid_r <= 1'b0;
      count_r     <= {(ADDR_W+2){1'b0}};
    end else begin
      wptr_r      <= wptr_nxt_s;
      rptr_r      <= rptr_nxt_s;
      inflight_r  <= rd_issue_s;
      ob_state_r  <= ob_state_nxt_s;
      ob_head_r   <= ob_head_nxt_s;
      ob_tail_r   <= ob_tail_nxt_s;
      ram_full_r  <= (ram_cnt_nxt_s == DEPTH_V);
      out_valid_r <= (ob_state_nxt_s != OB_EMPTY);
      count_r     <= count_nxt_s;
    end
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Randomized and directed bench for fifo_ram_ctrl with a behavioural RAM and a queue scoreboard.
module tb_fifo_ram_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [ADDR_W+1:0] count;
  logic              ram_full;

  logic [DATA_W-1:0] mem [0:15];
  logic [DATA_W-1:0] sb [$];
  int                n_checks = 0;
  int                n_errs   = 0;
  int                pops     = 0;
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;

  fifo_ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .count(count), .ram_full(ram_full)
  );

  always #5 clk = ~clk;

  // 16x8 RAM with registered read
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, evaluate handshakes mid-cycle against the model, check count after the edge
  task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic ordy);
    logic push;
    logic pop;
    logic [DATA_W-1:0] exp;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    push = in_valid & in_ready;
    pop  = out_valid & out_ready;
    if (sb.size() == 0) check_val("empty_no_valid", 32'(out_valid), 32'd0);
    if (sb.size() < 16) check_val("in_ready_open", 32'(in_ready), 32'd1);
    if (sb.size() >= 18) check_val("in_ready_full", 32'(in_ready), 32'd0);
    check_val("wr_en", 32'(ram_wr_en), 32'(push));
    if (prev_stall) begin
      check_val("stall_valid", 32'(out_valid), 32'd1);
      check_val("stall_data", 32'(out_data), 32'(prev_data));
    end
    prev_stall = out_valid & ~out_ready;
    prev_data  = out_data;
    if (pop) begin
      if (sb.size() == 0) begin
        check_val("pop_when_empty", 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        check_val("out_data", 32'(out_data), 32'(exp));
        pops++;
      end
    end
    if (push) sb.push_back(in_data);
    @(posedge clk);
    #1;
    check_val("count", 32'(count), 32'(sb.size()));
    check_val("count_max", 32'(count <= 6'd18), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) step(1'b0, 8'h00, 1'b1);
    check_val("drain_done", 32'(sb.size()), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check_val("drained_valid", 32'(out_valid), 32'd0);
    check_val("drained_count", 32'(count), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_ram_full", 32'(ram_full), 32'd0);
    check_val("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check_val("rst_rd_en", 32'(ram_rd_en), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rel_in_ready", 32'(in_ready), 32'd1);
    check_val("rel_out_valid", 32'(out_valid), 32'd0);
    check_val("rel_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;

    // Single word latency: push at edge N, valid only after edge N+2
    step(1'b1, 8'hA5, 1'b0);
    in_valid = 1'b0;
    check_val("lat_n0", 32'(out_valid), 32'd0);
    check_val("lat_count", 32'(count), 32'd1);
    @(posedge clk);
    #1;
    check_val("lat_n1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_val("lat_n2", 32'(out_valid), 32'd1);
    check_val("lat_data", 32'(out_data), 32'hA5);
    step(1'b0, 8'h00, 1'b1);
    check_val("single_count", 32'(count), 32'd0);
    drain();

    // Fill to 18 with consumer stalled; 19th push refused
    for (int i = 0; i < 19; i++) step(1'b1, 8'(i), 1'b0);
    check_val("fill_full", 32'(ram_full), 32'd1);
    check_val("fill_in_ready", 32'(in_ready), 32'd0);
    check_val("fill_count", 32'(count), 32'd18);
    check_val("fill_sb", 32'(sb.size()), 32'd18);
    check_val("fill_last", 32'(sb[17]), 32'h11);
    drain();

    // Streaming: one pop per cycle once primed
    pops = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1);
    check_val("stream_pops", 32'(pops), 32'd37);
    drain();

    // Random backpressure on both sides
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    drain();

    // Reset with seven words held and a read in flight
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("mid_rd_en", 32'(ram_rd_en), 32'd1);
    @(posedge clk);
    #1;
    check_val("mid_count", 32'(count), 32'd7);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_count", 32'(count), 32'd0);
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    prev_stall = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pops = 0;
    step(1'b1, 8'h3C, 1'b0);
    drain();
    check_val("mid_first_pop", 32'(pops), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
